// File: rtl/flow_table_prio.sv
// flow_table_prio: prioritised masked-match table on an AXI-Stream header path, two-stage pipeline.
// Optional per-entry hit counters are enabled by defining FLOW_TABLE_PRIO_ENTRY_STATS_EN.
module flow_table_prio #(
  parameter int HDR_TDATA_WIDTH    = 64,
  parameter int HDR_TUSER_WIDTH    = 32,
  parameter int KEY_WIDTH          = 32,
  parameter int KEY_POS            = 0,
  parameter int NUM_ENTRIES        = 8,
  parameter int ACT_WIDTH          = 8,
  parameter int ACT_POS            = 48,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  localparam int ADDR_W            = $clog2(NUM_ENTRIES)
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic [HDR_TDATA_WIDTH-1:0]    s_axis_hdr_tdata,
  input  logic [HDR_TUSER_WIDTH-1:0]    s_axis_hdr_tuser,
  input  logic                          s_axis_hdr_tvalid,
  output logic                          s_axis_hdr_tready,
  output logic [HDR_TDATA_WIDTH-1:0]    m_axis_hdr_tdata,
  output logic [HDR_TUSER_WIDTH-1:0]    m_axis_hdr_tuser,
  output logic                          m_axis_hdr_tvalid,
  input  logic                          m_axis_hdr_tready,
  input  logic [1:0]                    cfg_mode,
  input  logic [ADDR_W-1:0]             tbl_addr,
  input  logic                          tbl_wren,
  input  logic [KEY_WIDTH-1:0]          tbl_key,
  input  logic [KEY_WIDTH-1:0]          tbl_mask,
  input  logic [ACT_WIDTH-1:0]          tbl_act,
  input  logic                          tbl_valid,
  input  logic [ACT_WIDTH-1:0]          default_act,
  output logic [C_S_AXI_DATA_WIDTH-1:0] hit_total,
  output logic [C_S_AXI_DATA_WIDTH-1:0] miss_total,
  input  logic [ADDR_W-1:0]             stat_addr,
  input  logic                          stat_rden,
  output logic [C_S_AXI_DATA_WIDTH-1:0] stat_data,
  input  logic                          stat_clr
);
  localparam int RES_W = ACT_WIDTH + 2;
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] sat_inc(input logic [C_S_AXI_DATA_WIDTH-1:0] c);
    if (c == CNT_MAX) return c;
    else return c + CNT_ONE;
  endfunction

  logic [KEY_WIDTH-1:0]       key_r  [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0]       mask_r [NUM_ENTRIES];
  logic [ACT_WIDTH-1:0]       act_r  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]     vld_r;

  logic                       s1_valid_r;
  logic [HDR_TDATA_WIDTH-1:0] s1_data_r;
  logic [HDR_TUSER_WIDTH-1:0] s1_user_r;
  logic [1:0]                 s1_mode_r;
  logic [NUM_ENTRIES-1:0]     s1_match_r;
  logic [ACT_WIDTH-1:0]       s1_act_r;

  logic                       adv_s;
  logic                       out_hs_s;
  logic [NUM_ENTRIES-1:0]     match_s;
  logic [ACT_WIDTH-1:0]       win_act_s;
  logic                       hit_s;
  logic [ADDR_W-1:0]          idx_s;
  logic                       lookup_s;
  logic                       update_s;
  logic [HDR_TDATA_WIDTH-1:0] res_data_s;

  logic                       m_lookup_r;
  logic                       m_hit_r;
  logic [ADDR_W-1:0]          m_idx_r;

  assign adv_s             = ~m_axis_hdr_tvalid | m_axis_hdr_tready;
  assign s_axis_hdr_tready = axi_resetn & ~(s1_valid_r & ~adv_s);
  assign out_hs_s          = m_axis_hdr_tvalid & m_axis_hdr_tready;

  // Entry write port; only the valid bits need clearing on reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      vld_r <= '0;
    end else if (tbl_wren && (int'(tbl_addr) < NUM_ENTRIES)) begin
      key_r[tbl_addr]  <= tbl_key;
      mask_r[tbl_addr] <= tbl_mask;
      act_r[tbl_addr]  <= tbl_act;
      vld_r[tbl_addr]  <= tbl_valid;
    end
  end

  // Match the incoming key; the winning action is captured now so a later table write cannot alter it.
  always_comb begin
    match_s   = '0;
    win_act_s = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      match_s[i] = vld_r[i] &
                   (((s_axis_hdr_tdata[KEY_POS +: KEY_WIDTH] ^ key_r[i]) & ~mask_r[i]) == '0);
      if (match_s[i]) win_act_s = act_r[i];
      else            win_act_s = win_act_s;
    end
  end

  // Stage 1 register: beat, normalised mode and match vector.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_user_r  <= '0;
      s1_mode_r  <= 2'b01;
      s1_match_r <= '0;
      s1_act_r   <= '0;
    end else if (s_axis_hdr_tready) begin
      s1_valid_r <= s_axis_hdr_tvalid;
      if (s_axis_hdr_tvalid) begin
        s1_data_r  <= s_axis_hdr_tdata;
        s1_user_r  <= s_axis_hdr_tuser;
        s1_mode_r  <= (cfg_mode == 2'b11) ? 2'b01 : cfg_mode;
        s1_match_r <= match_s;
        s1_act_r   <= win_act_s;
      end
    end
  end

  // Priority encode (lowest index wins) and build the output beat.
  always_comb begin
    hit_s = |s1_match_r;
    idx_s = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (s1_match_r[i]) idx_s = ADDR_W'(i);
      else               idx_s = idx_s;
    end
    case (s1_mode_r)
      2'b00:   begin lookup_s = 1'b1; update_s = 1'b1; end
      2'b10:   begin lookup_s = 1'b1; update_s = 1'b0; end
      default: begin lookup_s = 1'b0; update_s = 1'b0; end
    endcase
    res_data_s = s1_data_r;
    if (update_s) res_data_s[ACT_POS +: RES_W] = {~hit_s, hit_s, hit_s ? s1_act_r : default_act};
    else          res_data_s = s1_data_r;
  end

  // Stage 2 (output) register.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      m_axis_hdr_tvalid <= 1'b0;
      m_axis_hdr_tdata  <= '0;
      m_axis_hdr_tuser  <= '0;
      m_lookup_r        <= 1'b0;
      m_hit_r           <= 1'b0;
      m_idx_r           <= '0;
    end else if (adv_s) begin
      m_axis_hdr_tvalid <= s1_valid_r;
      if (s1_valid_r) begin
        m_axis_hdr_tdata <= res_data_s;
        m_axis_hdr_tuser <= s1_user_r;
        m_lookup_r       <= lookup_s;
        m_hit_r          <= hit_s;
        m_idx_r          <= idx_s;
      end
    end
  end

  // Global counters count at the output handshake; a clear beats a concurrent increment.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn || stat_clr) begin
      hit_total  <= '0;
      miss_total <= '0;
    end else if (out_hs_s && m_lookup_r) begin
      if (m_hit_r) hit_total  <= sat_inc(hit_total);
      else         miss_total <= sat_inc(miss_total);
    end
  end

`ifdef FLOW_TABLE_PRIO_ENTRY_STATS_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] ent_cnt_r [NUM_ENTRIES];

  // Per-entry hit counters.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn || stat_clr) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_cnt_r[i] <= '0;
    end else if (out_hs_s && m_lookup_r && m_hit_r) begin
      ent_cnt_r[m_idx_r] <= sat_inc(ent_cnt_r[m_idx_r]);
    end
  end

  // Read port: value appears the cycle after stat_rden and is held until the next read.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) stat_data <= '0;
    else if (stat_rden) stat_data <= ent_cnt_r[stat_addr];
  end
`else
  logic unused_stat_s;
  assign unused_stat_s = ^{stat_addr, stat_rden, m_idx_r};
  assign stat_data     = '0;
`endif

endmodule

// File: doc/flow_table_prio.md
FLOW_TABLE_PRIO -- requirements
Module: flow_table_prio

Interface
REQ-001 SHALL have parameter HDR_TDATA_WIDTH, default 64: header/action beat width.
REQ-002 SHALL have parameter HDR_TUSER_WIDTH, default 32: source-port metadata width.
REQ-003 SHALL have parameter KEY_WIDTH, default 32, and KEY_POS, default 0: lookup key is tdata[KEY_POS +: KEY_WIDTH].
REQ-004 SHALL have parameter NUM_ENTRIES, default 8 (2..64): match entries; ADDR_W = clog2(NUM_ENTRIES).
REQ-005 SHALL have parameter ACT_WIDTH, default 8, and ACT_POS, default 48: result field tdata[ACT_POS +: ACT_WIDTH+2] = {miss, hit, action}; ACT_POS+ACT_WIDTH+2 <= HDR_TDATA_WIDTH.
REQ-006 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: counter width.
REQ-007 axi_aclk  in  1  sole clock; axi_resetn  in  1  synchronous active-low reset.
REQ-008 s_axis_hdr_tdata/tuser  in  HDR_TDATA_WIDTH/HDR_TUSER_WIDTH  input beat; s_axis_hdr_tvalid in 1; s_axis_hdr_tready out 1.
REQ-009 m_axis_hdr_tdata/tuser  out  HDR_TDATA_WIDTH/HDR_TUSER_WIDTH  output beat; m_axis_hdr_tvalid out 1; m_axis_hdr_tready in 1.
REQ-010 cfg_mode  in  2  00 active, 01 bypass, 10 lookup without tdata update, 11 treated as 01.
REQ-011 tbl_addr in ADDR_W; tbl_wren in 1 (pulse); tbl_key, tbl_mask in KEY_WIDTH; tbl_act in ACT_WIDTH; tbl_valid in 1: entry write port.
REQ-012 default_act  in  ACT_WIDTH  action applied on miss.
REQ-013 hit_total, miss_total  out  C_S_AXI_DATA_WIDTH  global counters.
REQ-014 stat_addr in ADDR_W; stat_rden in 1; stat_data out C_S_AXI_DATA_WIDTH; stat_clr in 1 (pulse).

Function
REQ-015 Beat accepted when s_axis_hdr_tvalid & s_axis_hdr_tready; adv = ~m_axis_hdr_tvalid | m_axis_hdr_tready; s_axis_hdr_tready = ~(stage1 valid & ~adv).
REQ-016 Two-stage pipeline: stage1 registers beat, cfg_mode and per-entry match vector; stage2 (output register) holds priority-encoded result; beat accepted at edge k visible on m_axis at edge k+2 with no stall.
REQ-017 Entry i matches iff valid_i & (((key ^ key_i) & ~mask_i) == 0); mask bit 1 = don't care.
REQ-018 Lowest matching index wins; hit=1, miss=0, action=act_i; no match: hit=0, miss=1, action=default_act.
REQ-019 Mode 00: output tdata = input with result field overwritten; mode 10: tdata unchanged, counters still update; mode 01: tdata unchanged, no lookup, no counter update; tuser always passes unchanged.
REQ-020 cfg_mode sampled per beat at acceptance; changes never affect in-flight beats.
REQ-021 tbl_wren writes entry tbl_addr at the edge; a beat accepted in the same cycle uses the previous contents.
REQ-022 Stall: output register and stage1 hold all values while m_axis_hdr_tvalid & ~m_axis_hdr_tready; no beat dropped or duplicated.
REQ-023 hit_total/miss_total increment on output handshake of a mode 00/10 beat; saturate at all-ones.
REQ-024 stat_clr clears all counters; clear wins over a simultaneous increment.

Reset
REQ-025 On axi_resetn=0 at an edge: all valids 0, m_axis outputs 0, s_axis_hdr_tready 0 during reset, every tbl_valid 0, all counters 0, stat_data 0.
REQ-026 Reset mid-stall discards in-flight beats; tready=1 the first cycle after release.

Configuration
REQ-027 Macro FLOW_TABLE_PRIO_ENTRY_STATS_EN defined: per-entry hit counters (saturating, cleared by stat_clr), stat_data = counter[stat_addr] registered one cycle after stat_rden, held otherwise.
REQ-028 Macro undefined: no per-entry counters; stat_data constant 0; hit_total/miss_total unaffected.

Verification
REQ-029 Entry 2 key 0x0A000001 mask 0, entry 5 mask 0xFFFFFFFF, mode 00, key 0x0A000001 -> result {0,1,act_2} at k+2, hit_total=1.
REQ-030 Only entry 5 valid (mask all-ones), any key -> hit, act_5; all invalid, default_act 0x3C -> {1,0,0x3C}, miss_total=1.
REQ-031 Mode 01 with 4 beats -> tdata bit-identical, counters 0; mode 10 -> tdata identical, counters advance by 4.
REQ-032 m_axis_hdr_tready low 5 cycles during a 10-beat burst -> all 10 beats out in order, s_axis_hdr_tready drops by second stalled cycle.
REQ-033 Write entry 0 in acceptance cycle of beat A, then beat B -> A uses old entry, B new; miss_total preloaded all-ones stays all-ones.
REQ-034 With FLOW_TABLE_PRIO_ENTRY_STATS_EN: 3 hits on entry 1, stat_rden addr 1 -> stat_data=3 next cycle; stat_clr with concurrent hit -> 0.
